// File: rtl/nco_pkg.sv
// Shared constants and elaboration-time helpers for the quadrature NCO.
// Contents: quadrant codes, output amplitude, quarter-table depth and the
// integer quarter-wave sine generator used to build the table when no
// image file is supplied.
package nco_pkg;

    // Quadrant codes: the top two phase-index bits
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Peak amplitude for a signed output of sw bits
    function automatic int unsigned nco_amp(input int unsigned sw);
        return (32'd1 << (sw - 32'd1)) - 32'd1;
    endfunction

    // Quarter-wave table depth, both end points included
    function automatic int unsigned rom_depth(input int unsigned lw);
        return (32'd1 << (lw - 32'd2)) + 32'd1;
    endfunction

    // round(amp * sin(pi/2 * j/q)) in Q30 fixed point via a Taylor series.
    // Only ever evaluated with constant arguments.
    function automatic int unsigned nco_quarter_sine(input int unsigned j,
                                                     input int unsigned q,
                                                     input int unsigned amp);
        longint x;
        longint term;
        longint sum;
        longint den;
        longint scaled;
        x    = (64'sd1686629713 * longint'(64'(j))) / longint'(64'(q));
        term = x;
        sum  = x;
        for (int n = 1; n <= 9; n++) begin
            den  = longint'((2 * n) * (2 * n + 1));
            term = -((((term * x) >>> 30) * x) >>> 30) / den;
            sum  = sum + term;
        end
        scaled = (sum * longint'(64'(amp)) + (64'sd1 <<< 29)) >>> 30;
        if (scaled < 0) begin
            scaled = 0;
        end
        if (scaled > longint'(64'(amp))) begin
            scaled = longint'(64'(amp));
        end
        return 32'(scaled);
    endfunction

endpackage

// File: rtl/nco_quarter_rom.sv
// Quarter-wave sine table, Q+1 unsigned words, two registered read ports.
// Ports:
//   clk       in   clock
//   sin_addr  in   LUT_WIDTH-1 bit address, port A
//   cos_addr  in   LUT_WIDTH-1 bit address, port B
//   sin_data  out  SINE_WIDTH-1 bit word at sin_addr, one clk later
//   cos_data  out  SINE_WIDTH-1 bit word at cos_addr, one clk later
// The table is built at elaboration from the package generator.
module nco_quarter_rom
    import nco_pkg::*;
#(
    parameter int unsigned LUT_WIDTH  = 10,
    parameter int unsigned SINE_WIDTH = 12,
    parameter string       ROM_FILE   = "quarter_sine.mem"
) (
    input  logic                    clk,
    input  logic [LUT_WIDTH-2:0]    sin_addr,
    input  logic [LUT_WIDTH-2:0]    cos_addr,
    output logic [SINE_WIDTH-2:0]   sin_data,
    output logic [SINE_WIDTH-2:0]   cos_data
);

    localparam int unsigned DW    = SINE_WIDTH - 1;
    localparam int unsigned DEPTH = rom_depth(LUT_WIDTH);
    localparam int unsigned QW    = 32'd1 << (LUT_WIDTH - 2);
    localparam int unsigned AMP   = nco_amp(SINE_WIDTH);

    logic [DW-1:0] table_mem [DEPTH];

    for (genvar j = 0; j < DEPTH; j++) begin : g_word
        assign table_mem[j] = DW'(nco_quarter_sine(j, QW, AMP));
    end

    // Synchronous reads; data registers carry no reset
    always_ff @(posedge clk) begin
        sin_data <= table_mem[sin_addr];
        cos_data <= table_mem[cos_addr];
    end

endmodule

// File: rtl/quadrature_nco.sv
// Quadrature NCO: phase accumulator plus quarter-wave lookup, sine and
// cosine out three clk edges after each sample_clk_ce.
// Ports:
//   clk              in   clock
//   arst             in   asynchronous reset, active-high
//   sample_clk_ce    in   advance accumulator and launch one sample
//   phase_clear      in   synchronous accumulator clear (wins over ce)
//   phase_increment  in   PHASE_WIDTH signed tuning word
//   phase_offset     in   PHASE_WIDTH phase added after the accumulator
//   sin_out          out  SINE_WIDTH signed A*sin(phase)
//   cos_out          out  SINE_WIDTH signed A*cos(phase)
//   out_valid        out  one-clk strobe per launched sample
module quadrature_nco
    import nco_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = 64,
    parameter int unsigned LUT_WIDTH   = 10,
    parameter int unsigned SINE_WIDTH  = 12,
    parameter string       ROM_FILE    = "quarter_sine.mem"
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          sample_clk_ce,
    input  logic                          phase_clear,
    input  logic [PHASE_WIDTH-1:0]        phase_increment,
    input  logic [PHASE_WIDTH-1:0]        phase_offset,
    output logic signed [SINE_WIDTH-1:0]  sin_out,
    output logic signed [SINE_WIDTH-1:0]  cos_out,
    output logic                          out_valid
);

    localparam int unsigned AW      = LUT_WIDTH - 1;
    localparam int unsigned KW      = LUT_WIDTH - 2;
    localparam int unsigned DW      = SINE_WIDTH - 1;
    localparam int unsigned QUARTER = 32'd1 << KW;

    logic [PHASE_WIDTH-1:0]       acc;
    logic [LUT_WIDTH-1:0]         phase_idx;
    logic                         v1, v2, v3;
    logic [1:0]                   quad1;
    logic [KW-1:0]                k1;
    logic [1:0]                   quad2, quad3;
    logic [AW-1:0]                sin_addr, cos_addr;
    logic [DW-1:0]                sin_mag, cos_mag;
    logic signed [SINE_WIDTH-1:0] sin_ext, cos_ext;
    logic                         sin_neg, cos_neg;

    // Phase accumulator; wraps modulo 2^PHASE_WIDTH, clear overrides ce
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            acc <= '0;
        end else if (phase_clear) begin
            acc <= '0;
        end else if (sample_clk_ce) begin
            acc <= acc + phase_increment;
        end
    end

    // Stage 1: truncated lookup phase from the pre-increment accumulator
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            phase_idx <= '0;
            v1        <= 1'b0;
        end else begin
            v1 <= sample_clk_ce;
            if (sample_clk_ce) begin
                phase_idx <= LUT_WIDTH'((acc + phase_offset) >> (PHASE_WIDTH - LUT_WIDTH));
            end
        end
    end

    assign quad1 = phase_idx[LUT_WIDTH-1 -: 2];
    assign k1    = phase_idx[KW-1:0];

    // Stage 2: fold the phase into the quarter table; odd quadrants mirror
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            quad2    <= Q0;
            sin_addr <= '0;
            cos_addr <= '0;
            v2       <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                quad2    <= quad1;
                sin_addr <= quad1[0] ? AW'(QUARTER) - AW'(k1) : AW'(k1);
                cos_addr <= quad1[0] ? AW'(k1) : AW'(QUARTER) - AW'(k1);
            end
        end
    end

    // Stage 3: table read; quadrant travels alongside the ROM latency
    nco_quarter_rom #(
        .LUT_WIDTH  (LUT_WIDTH),
        .SINE_WIDTH (SINE_WIDTH),
        .ROM_FILE   (ROM_FILE)
    ) u_rom (
        .clk      (clk),
        .sin_addr (sin_addr),
        .cos_addr (cos_addr),
        .sin_data (sin_mag),
        .cos_data (cos_mag)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            quad3 <= Q0;
            v3    <= 1'b0;
        end else begin
            v3 <= v2;
            if (v2) begin
                quad3 <= quad2;
            end
        end
    end

    // Sign restore: sine negative in Q2/Q3, cosine negative in Q1/Q2
    assign sin_ext = SINE_WIDTH'(sin_mag);
    assign cos_ext = SINE_WIDTH'(cos_mag);
    assign sin_neg = (quad3 == Q2) || (quad3 == Q3);
    assign cos_neg = (quad3 == Q1) || (quad3 == Q2);

    // Output stage: samples update only on a valid, otherwise hold
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sin_out   <= '0;
            cos_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v3;
            if (v3) begin
                sin_out <= sin_neg ? -sin_ext : sin_ext;
                cos_out <= cos_neg ? -cos_ext : cos_ext;
            end
        end
    end

endmodule

// File: tb/tb_quadrature_nco.sv
// Directed and scoreboard bench for quadrature_nco (PW=64, LW=10, SW=12).
module tb_quadrature_nco;

    localparam int  AMP     = 2047;
    localparam int  SWEEP_N = 20000;
    localparam real PI      = 3.14159265358979;

    localparam logic [63:0] P_EIGHTH  = 64'h2000_0000_0000_0000;
    localparam logic [63:0] P_QUARTER = 64'h4000_0000_0000_0000;
    localparam logic [63:0] P_HALF    = 64'h8000_0000_0000_0000;
    localparam logic [63:0] P_NEG_Q   = 64'hC000_0000_0000_0000;

    logic               clk = 1'b0;
    logic               arst = 1'b0;
    logic               ce = 1'b0;
    logic               clr = 1'b0;
    logic [63:0]        inc = '0;
    logic [63:0]        off = '0;
    logic signed [11:0] sin_out;
    logic signed [11:0] cos_out;
    logic               out_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int got_sin_q[$];
    int got_cos_q[$];
    int exp_sin_q[$];
    int exp_cos_q[$];

    quadrature_nco #(
        .PHASE_WIDTH (64),
        .LUT_WIDTH   (10),
        .SINE_WIDTH  (12),
        .ROM_FILE    ("")
    ) dut (
        .clk             (clk),
        .arst            (arst),
        .sample_clk_ce   (ce),
        .phase_clear     (clr),
        .phase_increment (inc),
        .phase_offset    (off),
        .sin_out         (sin_out),
        .cos_out         (cos_out),
        .out_valid       (out_valid)
    );

    always #5 clk = ~clk;

    // Capture every valid sample away from the active edge
    always @(negedge clk) begin
        if (out_valid) begin
            got_sin_q.push_back(int'(sin_out));
            got_cos_q.push_back(int'(cos_out));
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp,
                            input longint tol = 0);
        longint diff;
        diff = got - exp;
        n_checks++;
        if (diff > tol || diff < -tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        ce   = 1'b0;
        clr  = 1'b0;
        step();
        step();
        arst = 1'b0;
        step();
    endtask

    task automatic exp_push(input int s, input int c);
        exp_sin_q.push_back(s);
        exp_cos_q.push_back(c);
    endtask

    task automatic run_stream(input int n);
        ce = 1'b1;
        repeat (n) step();
        ce = 1'b0;
        repeat (6) step();
    endtask

    task automatic compare_samples(input string tag, input longint tol = 0);
        int n;
        check_eq({tag, "_count"}, got_sin_q.size(), exp_sin_q.size());
        n = (got_sin_q.size() < exp_sin_q.size()) ? got_sin_q.size() : exp_sin_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_sin[%0d]", tag, i), got_sin_q[i], exp_sin_q[i], tol);
            check_eq($sformatf("%s_cos[%0d]", tag, i), got_cos_q[i], exp_cos_q[i], tol);
        end
        got_sin_q.delete();
        got_cos_q.delete();
        exp_sin_q.delete();
        exp_cos_q.delete();
    endtask

    initial begin
        int          lat;
        int          ps [5];
        int          pc [5];
        logic        ce_t [7];
        logic        clr_t [7];
        logic [63:0] acc_m;
        logic [63:0] phase;
        int          idx;
        real         rs;
        real         rc;

        // Reset state
        arst = 1'b1;
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_sin", sin_out, 0);
        check_eq("rst_cos", cos_out, 0);
        do_reset();

        // 1: quarter-turn steps, latency of the first sample
        inc = P_QUARTER;
        off = '0;
        for (int i = 0; i < 2; i++) begin
            exp_push(0, AMP);
            exp_push(AMP, 0);
            exp_push(0, -AMP);
            exp_push(-AMP, 0);
        end
        ce = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("t1_latency", lat, 3);
        @(negedge clk);
        repeat (4) step();
        ce = 1'b0;
        repeat (6) step();
        compare_samples("t1");

        // 2: reverse rotation through the wrap
        do_reset();
        inc = P_NEG_Q;
        exp_push(0, AMP);
        exp_push(-AMP, 0);
        exp_push(0, -AMP);
        exp_push(AMP, 0);
        exp_push(0, AMP);
        run_stream(5);
        compare_samples("t2");

        // 3: static phase from the offset alone, then an offset change
        do_reset();
        inc = '0;
        off = P_QUARTER;
        repeat (3) exp_push(AMP, 0);
        run_stream(3);
        compare_samples("t3a");
        off = P_HALF;
        repeat (3) exp_push(0, -AMP);
        run_stream(3);
        compare_samples("t3b");

        // 4: isolated ce pulses; one valid each, outputs hold in between
        do_reset();
        inc = P_EIGHTH;
        off = '0;
        ps = '{0, 1447, 2047, 1447, 0};
        pc = '{2047, 1447, 0, -1447, -2047};
        for (int p = 0; p < 5; p++) begin
            ce = 1'b1;
            step();
            ce = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                check_eq($sformatf("t4_valid[%0d.%0d]", p, k), out_valid, (k == 4) ? 1 : 0);
                check_eq($sformatf("t4_sin[%0d.%0d]", p, k), sin_out,
                         (k >= 4) ? ps[p] : ((p == 0) ? 0 : ps[p-1]));
                check_eq($sformatf("t4_cos[%0d.%0d]", p, k), cos_out,
                         (k >= 4) ? pc[p] : ((p == 0) ? 0 : pc[p-1]));
                if (k < 5) step();
            end
        end
        repeat (4) step();
        for (int p = 0; p < 5; p++) exp_push(ps[p], pc[p]);
        compare_samples("t4_seq");

        // 5: clear alone, then clear together with ce
        do_reset();
        inc = P_EIGHTH;
        ce_t  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        clr_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            ce  = ce_t[i];
            clr = clr_t[i];
            step();
        end
        ce  = 1'b0;
        clr = 1'b0;
        repeat (6) step();
        exp_push(0, AMP);
        exp_push(1447, 1447);
        exp_push(AMP, 0);
        exp_push(0, AMP);
        exp_push(1447, 1447);
        exp_push(0, AMP);
        compare_samples("t5");

        // 6: reset with samples in flight
        do_reset();
        inc = P_QUARTER;
        exp_push(0, AMP);
        exp_push(AMP, 0);
        exp_push(0, -AMP);
        exp_push(-AMP, 0);
        run_stream(4);
        compare_samples("t6_pre");
        ce = 1'b1;
        repeat (3) step();
        ce   = 1'b0;
        arst = 1'b1;
        #1;
        check_eq("t6_arst_valid", out_valid, 0);
        check_eq("t6_arst_sin", sin_out, 0);
        check_eq("t6_arst_cos", cos_out, 0);
        step();
        arst = 1'b0;
        repeat (8) step();
        compare_samples("t6_nostale");
        exp_push(0, AMP);
        run_stream(1);
        compare_samples("t6_first");

        // Random increment/offset sweep against a real-valued model
        do_reset();
        acc_m = '0;
        for (int i = 0; i < SWEEP_N; i++) begin
            inc   = {$urandom, $urandom};
            off   = {$urandom, $urandom};
            ce    = 1'b1;
            phase = acc_m + off;
            idx   = int'(phase[63:54]);
            rs    = AMP * $sin(2.0 * PI * idx / 1024.0);
            rc    = AMP * $cos(2.0 * PI * idx / 1024.0);
            exp_push((rs >= 0.0) ? $rtoi(rs + 0.5) : -$rtoi(-rs + 0.5),
                     (rc >= 0.0) ? $rtoi(rc + 0.5) : -$rtoi(-rc + 0.5));
            acc_m = acc_m + inc;
            step();
        end
        ce = 1'b0;
        repeat (6) step();
        compare_samples("sweep", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
